mem_wb_pipe: RTL

//   Parametrised MEM->WB pipeline register for the ARM core, replacing the fixed 1-stage register.

---
 rtl/mem_wb_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with 1..4 retiming stages, flush-over-freeze priority,
// write-back value select and RAW hazard detection across all in-flight stages.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic [DATA_W-1:0] AluRes,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DEST_W-1:0] dest,
  input  logic [DEST_W-1:0] src1,
  input  logic [DEST_W-1:0] src2,
  input  logic              two_src,
  output logic              out_valid,
  output logic              WB_EN_OUT,
  output logic              MEM_R_EN_OUT,
  output logic [DATA_W-1:0] AluRes_OUT,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DEST_W-1:0] destOut,
  output logic [DATA_W-1:0] wb_value,
  output logic              hazard
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mem_wb_pipe: STAGES must be in 1..4");
    end
  endgenerate

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] wb_en_q;
  logic [STAGES-1:0] mem_r_en_q;
  logic [DATA_W-1:0] alu_q  [STAGES];
  logic [DATA_W-1:0] mem_q  [STAGES];
  logic [DEST_W-1:0] dest_q [STAGES];

  // Flush only kills valid/wb_en; payload is kept so the raw *_OUT fields stay observable.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      wb_en_q    <= '0;
      mem_r_en_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        alu_q[k]  <= '0;
        mem_q[k]  <= '0;
        dest_q[k] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      wb_en_q <= '0;
    end else if (!freeze) begin
      valid_q[0]    <= in_valid;
      wb_en_q[0]    <= WB_EN & in_valid;
      mem_r_en_q[0] <= MEM_R_EN;
      alu_q[0]      <= AluRes;
      mem_q[0]      <= mem_data;
      dest_q[0]     <= dest;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k]    <= valid_q[k-1];
        wb_en_q[k]    <= wb_en_q[k-1];
        mem_r_en_q[k] <= mem_r_en_q[k-1];
        alu_q[k]      <= alu_q[k-1];
        mem_q[k]      <= mem_q[k-1];
        dest_q[k]     <= dest_q[k-1];
      end
    end
  end

  assign out_valid    = valid_q[LAST];
  assign WB_EN_OUT    = valid_q[LAST] & wb_en_q[LAST];
  assign MEM_R_EN_OUT = mem_r_en_q[LAST];
  assign AluRes_OUT   = alu_q[LAST];
  assign mem_data_out = mem_q[LAST];
  assign destOut      = dest_q[LAST];
  assign wb_value     = mem_r_en_q[LAST] ? mem_q[LAST] : alu_q[LAST];

  // R0 is a real register, so dest == 0 matches like any other index.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (valid_q[k] && wb_en_q[k] &&
          ((dest_q[k] == src1) || (two_src && (dest_q[k] == src2)))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule
